// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch state encoding and ARF control codes
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH_L = 2'd1,
    S_FETCH_H = 2'd2,
    S_DONE    = 2'd3
  } fetch_state_e;

  localparam logic [2:0] FUNSEL_DEC   = 3'b000;
  localparam logic [2:0] INC_CODE     = 3'b001;
  localparam logic [2:0] FUNSEL_LOAD  = 3'b010;
  localparam logic [2:0] FUNSEL_CLEAR = 3'b011;

  // RegSel enables are active-low: a 0 bit enables that register
  localparam logic [2:0] PC_EN_N   = 3'b011;
  localparam logic [2:0] NONE_EN_N = 3'b111;

  localparam logic [1:0] OUTD_PC = 2'b00;

endpackage

// File: rtl/instruction_register.sv
// rtl/instruction_register.sv - 16-bit IR with independent byte loads and sync clear
module instruction_register (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        ld_lo_i,
  input  logic        ld_hi_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] ir_o
);

  logic [15:0] ir_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      ir_q <= 16'h0000;
    end else begin
      if (ld_lo_i) ir_q[7:0]  <= byte_i;
      if (ld_hi_i) ir_q[15:8] <= byte_i;
    end
  end

  assign ir_o = ir_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - two-byte instruction fetch sequencer driving the ARF PC
module instruction_fetch_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [15:0] PCIn,
  input  logic [7:0]  MemData,
  output logic [15:0] MemAddr,
  output logic        MemRead,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [15:0] IROut,
  output logic        Busy,
  output logic        FetchDone
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         fetching;
  logic         advance;

  assign fetching = (state_q == S_FETCH_L) || (state_q == S_FETCH_H);
  // A byte is consumed (read, latched, PC bumped) only on an unstalled, unflushed fetch cycle
  assign advance  = fetching && !Stall && !Flush && !Reset;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    state_d = (Start && !Flush) ? S_FETCH_L : S_IDLE;
      S_FETCH_L: begin
        if (Flush)       state_d = S_IDLE;
        else if (!Stall) state_d = S_FETCH_H;
      end
      S_FETCH_H: begin
        if (Flush)       state_d = S_IDLE;
        else if (!Stall) state_d = S_DONE;
      end
      S_DONE:    state_d = (Start && !Flush) ? S_FETCH_L : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  instruction_register u_ir (
    .clk_i   (Clock),
    .clear_i (Reset),
    .ld_lo_i (advance && (state_q == S_FETCH_L)),
    .ld_hi_i (advance && (state_q == S_FETCH_H)),
    .byte_i  (MemData),
    .ir_o    (IROut)
  );

  assign MemAddr     = PCIn;
  assign ARF_OutDSel = OUTD_PC;
  assign ARF_FunSel  = INC_CODE;
  assign MemRead     = advance;
  assign ARF_RegSel  = advance ? PC_EN_N : NONE_EN_N;
  assign Busy        = fetching && !Reset;
  assign FetchDone   = (state_q == S_DONE) && !Reset;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench with ARF/memory model and random stimulus
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset, Start, Stall, Flush;
  logic [15:0] PCIn;
  logic [7:0]  MemData;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic [2:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic [1:0]  ARF_OutDSel;
  logic [15:0] IROut;
  logic        Busy;
  logic        FetchDone;

  instruction_fetch_unit dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Stall       (Stall),
    .Flush       (Flush),
    .PCIn        (PCIn),
    .MemData     (MemData),
    .MemAddr     (MemAddr),
    .MemRead     (MemRead),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_RegSel  (ARF_RegSel),
    .ARF_OutDSel (ARF_OutDSel),
    .IROut       (IROut),
    .Busy        (Busy),
    .FetchDone   (FetchDone)
  );

  always #5 Clock = ~Clock;

  logic [7:0] mem [0:65535];
  assign MemData = mem[PCIn];

  int total  = 0;
  int passed = 0;
  int dones  = 0;

  // Model: phase counts bytes fetched so far (0 idle, 1 low, 2 high, 3 word ready)
  int          ph;
  logic [15:0] ir_m;
  logic [15:0] pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input logic rst, input logic st, input logic sl, input logic fl);
    logic        fetch, take;
    int          ph_nx;
    logic [15:0] pc_nx, ir_nx;
    Reset = rst; Start = st; Stall = sl; Flush = fl; PCIn = pc;
    @(negedge Clock);
    fetch = !rst && (ph == 1 || ph == 2);
    take  = fetch && !sl && !fl;
    chk("memaddr",   {16'h0, MemAddr},     {16'h0, pc});
    chk("memread",   {31'h0, MemRead},     {31'h0, take});
    chk("regsel",    {29'h0, ARF_RegSel},  {29'h0, take ? 3'b011 : 3'b111});
    chk("funsel",    {29'h0, ARF_FunSel},  32'd1);
    chk("outdsel",   {30'h0, ARF_OutDSel}, 32'd0);
    chk("busy",      {31'h0, Busy},        {31'h0, fetch});
    chk("fetchdone", {31'h0, FetchDone},   {31'h0, !rst && ph == 3});
    chk("irout",     {16'h0, IROut},       {16'h0, ir_m});
    if (FetchDone === 1'b1) dones++;
    ph_nx = ph; pc_nx = pc; ir_nx = ir_m;
    if (rst) begin
      ph_nx = 0; ir_nx = 16'h0000;
    end else if (ph == 0 || ph == 3) begin
      ph_nx = (st && !fl) ? 1 : 0;
    end else if (fl) begin
      ph_nx = 0;
    end else if (!sl) begin
      if (ph == 1) ir_nx[7:0]  = mem[pc];
      else         ir_nx[15:8] = mem[pc];
      pc_nx = pc + 16'd1;
      ph_nx = ph + 1;
    end
    @(posedge Clock);
    #1;
    ph = ph_nx; pc = pc_nx; ir_m = ir_nx;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    Reset = 1'b1; Start = 1'b0; Stall = 1'b0; Flush = 1'b0;
    pc = 16'h0000; PCIn = 16'h0000; ph = 0; ir_m = 16'h0000;
    @(posedge Clock);
    #1;

    // single fetch from 0010
    pc = 16'h0010; mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12; dones = 0;
    cyc(1, 0, 0, 0);
    chk("reset_ir", {16'h0, IROut}, 32'h0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t1_ir",    {16'h0, IROut}, 32'h1234);
    chk("t1_model", {16'h0, ir_m},  32'h1234);
    chk("t1_pc",    {16'h0, pc},    32'h0012);
    chk("t1_dones", dones, 1);

    // back-to-back fetches with Start held
    pc = 16'h0020; dones = 0;
    mem[16'h0020] = 8'h78; mem[16'h0021] = 8'h56; mem[16'h0022] = 8'hBC; mem[16'h0023] = 8'h9A;
    repeat (4) cyc(0, 1, 0, 0);
    chk("t2_ir1", {16'h0, IROut}, 32'h5678);
    repeat (2) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t2_ir2",   {16'h0, IROut}, 32'h9ABC);
    chk("t2_pc",    {16'h0, pc},    32'h0024);
    chk("t2_dones", dones, 2);

    // stall twice in FETCH_H
    pc = 16'h0040; dones = 0; mem[16'h0040] = 8'hEF; mem[16'h0041] = 8'hBE;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t3_nodone", dones, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t3_ir",    {16'h0, IROut}, 32'hBEEF);
    chk("t3_dones", dones, 1);

    // flush in FETCH_H keeps old high byte and PC
    pc = 16'h0030; dones = 0; mem[16'h0030] = 8'h11; mem[16'h0031] = 8'h22;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    chk("t4_ir",    {16'h0, IROut}, 32'hBE11);
    chk("t4_pc",    {16'h0, pc},    32'h0031);
    chk("t4_dones", dones, 0);

    // reset in FETCH_L
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t5_ir", {16'h0, IROut}, 32'h0000);

    // PC wrap
    pc = 16'hFFFF; dones = 0; mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t6_ir",    {16'h0, IROut}, 32'hABCD);
    chk("t6_model", {16'h0, ir_m},  32'hABCD);
    chk("t6_pc",    {16'h0, pc},    32'h0001);

    // random mix
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 40) == 0, ($urandom % 3) != 0, ($urandom % 5) == 0, ($urandom % 9) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
